usb_ft_async_fifo_bridge: RTL
=============================

# usb_ft_async_fifo_bridge

Parametrised host-side bridge between an FTDI FT2232H/FT232H channel in asynchronous 245-FIFO mode and the on-chip command/register logic. It synchronises RXF#/TXE#, generates RD#/WR# strobes with programmable pulse and recovery widths, and buffers both directions in internal FIFOs. Decoders upstream see plain valid/ready byte streams in place of raw FTDI handshakes. It replaces the fixed-timing, unbuffered byte interface in front of the rx/tx/interrupt units.

## Interface
- RX_DEPTH, 16: RX FIFO depth in bytes, power of two, ≥4.
- TX_DEPTH, 16: TX FIFO depth in bytes, power of two, ≥4.
- RD_LOW, 3: clk cycles rd_n held low, 1..15; data sampled on the last low cycle.
- RD_HIGH, 2: clk cycles rd_n held high after a read before the next strobe, 1..15.
- WR_SETUP, 1: clk cycles data is driven before wr_n falls, 1..7.
- WR_LOW, 3: clk cycles wr_n held low, 1..15.
- WR_HIGH, 2: recovery cycles after wr_n rises, 1..15.
- RX_PRIORITY, 0: 1 = a pending read always wins; 0 = round-robin between read and write.

Ports:
- clk  in  1  system clock.
- n_reset  in  1  reset; asynchronous, active-low.
- rxf_n  in  1  FTDI RXF#, asynchronous, low = byte available.
- txe_n  in  1  FTDI TXE#, asynchronous, low = space available.
- rd_n  out  1  FTDI RD#.
- wr_n  out  1  FTDI WR#.
- usb_data  inout  8  FTDI data bus; driven only during write phases.
- flush  in  1  synchronous; empties both FIFOs, aborts nothing in progress on the pins.
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data valid (RX FIFO not empty).
- rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX FIFO not full.
- rx_level  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy.
- tx_level  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy.
- busy  out  1  pin state machine not in IDLE.

## Operation
- rxf_n and txe_n each pass through a 2-flop synchroniser. Both flops reset to 1 (not ready).
- Pin FSM states: IDLE, RD_LOW_S, RD_HIGH_S, WR_SETUP_S, WR_LOW_S, WR_HIGH_S. A single down-counter times every state.
- A read is eligible when the synchronised rxf_n = 0 and rx_level ≤ RX_DEPTH−1.
- A write is eligible when the synchronised txe_n = 0 and tx_level ≥ 1.
- From IDLE:
  - Only one eligible: go to it (RD_LOW_S or WR_SETUP_S).
  - Both eligible, RX_PRIORITY = 1: read.
  - Both eligible, RX_PRIORITY = 0: the opposite of the last completed access. The `last` bit resets to write, so the first tie goes to read.
- RD_LOW_S: rd_n = 0 for RD_LOW cycles. On the last cycle usb_data is registered and pushed to the RX FIFO. Then RD_HIGH_S for RD_HIGH cycles, then IDLE.
- WR_SETUP_S: the TX FIFO head is popped into the output register and usb_data is driven.
  - WR_LOW_S: wr_n = 0 for WR_LOW cycles.
  - WR_HIGH_S: data stays driven for 1 further cycle of hold, then goes Z. After WR_HIGH cycles the FSM returns to IDLE.
- No new strobe starts until RD_HIGH/WR_HIGH has elapsed. The synchronised flags are re-evaluated only in IDLE, so flag changes mid-strobe are ignored.
- FIFOs:
  - Push and pop in the same cycle are both performed and the level is unchanged.
  - Push when full and pop when empty are impossible by construction (eligibility and tx_ready/rx_valid).
  - Pointers wrap modulo depth; the level uses an extra MSB so full = DEPTH.
- flush zeroes both FIFO pointers next cycle. flush has priority over a same-cycle push or pop.
  - A read in progress still completes and pushes into the empty FIFO.
  - A write in progress still completes with its already-popped byte.

## Timing
- Reset values:
  - rd_n = 1, wr_n = 1, usb_data = Z.
  - rx_valid = 0, tx_ready = 1, rx_level = 0, tx_level = 0, busy = 0.
  - rx_data = 0x00, FSM in IDLE.
- Reset mid-strobe: strobes deassert and the bus releases asynchronously; any partial byte is discarded.
- Latency from rxf_n falling to rd_n falling is 3 cycles: 2 sync cycles + 1 IDLE decision.
- The RX byte is visible on rx_valid 1 cycle after its sampling edge (FWFT FIFO).
- Per-byte pin period:
  - Read: RD_LOW + RD_HIGH + 1 (IDLE) cycles.
  - Write: WR_SETUP + WR_LOW + WR_HIGH + 1 cycles.
- tx_ready and rx_valid are registered FIFO flags. The level outputs update 1 cycle after a push/pop.

## Structure
- Package usb_ft_pkg holds:
  - the FSM state enum;
  - the counter width constant CNT_W = 4;
  - a function checking parameter legality (power of two, ranges), used in an initial assertion.
- Sub-module usb_ft_sync_fifo (parameters WIDTH, DEPTH; FWFT; level output) is instantiated twice, for RX and TX.
- Synchronisers, arbiter and FSM live in the top.

## Test plan
- rxf_n held low, FTDI model supplies 0x11, 0x22, 0x33; rx_ready = 1, defaults → three rd_n pulses 3 cycles low / 2 high; rx_data sequence 0x11, 0x22, 0x33; first rd_n fall 3 cycles after rxf_n fall.
- Push 0xA5, 0x5A with txe_n low → usb_data = 0xA5 stable from 1 cycle before wr_n falls until 1 cycle after it rises; then 0x5A; tx_level ends at 0.
- rxf_n and txe_n both low, TX FIFO holds 4 bytes, RX_PRIORITY = 0 → accesses alternate R, W, R, W. With RX_PRIORITY = 1 → reads only until RX is full or rxf_n goes high.
- rx_ready = 0, RX_DEPTH = 4, rxf_n low → exactly 4 reads, rx_level = 4, rd_n stays high. After one pop, exactly one more read.
- n_reset asserted in cycle 2 of WR_LOW_S → wr_n = 1 and usb_data = Z immediately; all levels 0 after release.
- flush asserted while TX holds 3 bytes and a write is in WR_LOW_S → that byte completes on the pins, tx_level = 0 next cycle, no further wr_n pulses.

Source files
------------

// File: rtl/usb_ft_pkg.sv
// Shared types and constants for the FTDI async 245-FIFO bridge.
// Parameter legality is checked against the helpers below.
package usb_ft_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_LOW_S,
    RD_HIGH_S,
    WR_SETUP_S,
    WR_LOW_S,
    WR_HIGH_S
  } ft_state_t;

  function automatic bit pow2_ge4(input int d);
    return (d >= 4) && ((d & (d - 1)) == 0);
  endfunction

  function automatic bit in_rng(input int v, input int hi);
    return (v >= 1) && (v <= hi);
  endfunction

  function automatic bit params_ok(
    input int rx_d,
    input int tx_d,
    input int rd_l,
    input int rd_h,
    input int wr_s,
    input int wr_l,
    input int wr_h,
    input int rx_pri
  );
    return pow2_ge4(rx_d) && pow2_ge4(tx_d) &&
           in_rng(rd_l, 15) && in_rng(rd_h, 15) &&
           in_rng(wr_s, 7) && in_rng(wr_l, 15) &&
           in_rng(wr_h, 15) && (rx_pri inside {0, 1});
  endfunction

endpackage

// File: rtl/usb_ft_sync_fifo.sv
// First-word-fall-through single-clock FIFO with occupancy output.
// Pointers carry an extra MSB so a full FIFO reads level == DEPTH.
module usb_ft_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign level = wr_ptr - rd_ptr;
  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));
  // Hold the head at zero while empty so the output is defined after reset.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/usb_ft_async_fifo_bridge.sv
// FTDI async 245-FIFO pin engine with buffered valid/ready byte streams.
// One down-counter times every strobe phase of the pin FSM.
module usb_ft_async_fifo_bridge
  import usb_ft_pkg::*;
#(
  parameter int RX_DEPTH    = 16,
  parameter int TX_DEPTH    = 16,
  parameter int RD_LOW      = 3,
  parameter int RD_HIGH     = 2,
  parameter int WR_SETUP    = 1,
  parameter int WR_LOW      = 3,
  parameter int WR_HIGH     = 2,
  parameter int RX_PRIORITY = 0
) (
  input  logic                        clk,
  input  logic                        n_reset,
  input  logic                        rxf_n,
  input  logic                        txe_n,
  output logic                        rd_n,
  output logic                        wr_n,
  inout  wire  [7:0]                  usb_data,
  input  logic                        flush,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic                        busy
);

  if (!params_ok(RX_DEPTH, TX_DEPTH, RD_LOW, RD_HIGH,
                 WR_SETUP, WR_LOW, WR_HIGH, RX_PRIORITY)) begin : g_param_err
    $error("usb_ft_async_fifo_bridge: illegal parameters");
  end

  localparam logic [CNT_W-1:0] RD_LOW_C   = CNT_W'(RD_LOW - 1);
  localparam logic [CNT_W-1:0] RD_HIGH_C  = CNT_W'(RD_HIGH - 1);
  localparam logic [CNT_W-1:0] WR_SETUP_C = CNT_W'(WR_SETUP - 1);
  localparam logic [CNT_W-1:0] WR_LOW_C   = CNT_W'(WR_LOW - 1);
  localparam logic [CNT_W-1:0] WR_HIGH_C  = CNT_W'(WR_HIGH - 1);

  ft_state_t        state;
  ft_state_t        state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             last_rd;
  logic             last_nx;
  logic             rxf_s1;
  logic             rxf_s2;
  logic             txe_s1;
  logic             txe_s2;
  logic             rx_push;
  logic             tx_pop;
  logic             rx_empty;
  logic             rx_full;
  logic             tx_empty;
  logic             tx_full;
  logic [7:0]       tx_head;
  logic [7:0]       dout;
  logic             data_oe;
  logic             rd_ok;
  logic             wr_ok;
  logic             done;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rxf_s1 <= 1'b1;
      rxf_s2 <= 1'b1;
      txe_s1 <= 1'b1;
      txe_s2 <= 1'b1;
    end else begin
      rxf_s1 <= rxf_n;
      rxf_s2 <= rxf_s1;
      txe_s1 <= txe_n;
      txe_s2 <= txe_s1;
    end
  end

  assign rd_ok = !rxf_s2 && !rx_full;
  assign wr_ok = !txe_s2 && !tx_empty;
  assign done  = (cnt == '0);

  always_comb begin
    state_nx = state;
    cnt_nx   = done ? cnt : cnt - 1'b1;
    last_nx  = last_rd;
    rx_push  = 1'b0;
    tx_pop   = 1'b0;
    unique case (state)
      IDLE: begin
        // On a tie, round-robin picks the opposite of the last access.
        if (rd_ok && (!wr_ok || RX_PRIORITY != 0 || !last_rd)) begin
          state_nx = RD_LOW_S;
          cnt_nx   = RD_LOW_C;
        end else if (wr_ok) begin
          state_nx = WR_SETUP_S;
          cnt_nx   = WR_SETUP_C;
          tx_pop   = 1'b1;
        end
      end
      RD_LOW_S: if (done) begin
        rx_push  = 1'b1;
        state_nx = RD_HIGH_S;
        cnt_nx   = RD_HIGH_C;
      end
      RD_HIGH_S: if (done) begin
        state_nx = IDLE;
        last_nx  = 1'b1;
      end
      WR_SETUP_S: if (done) begin
        state_nx = WR_LOW_S;
        cnt_nx   = WR_LOW_C;
      end
      WR_LOW_S: if (done) begin
        state_nx = WR_HIGH_S;
        cnt_nx   = WR_HIGH_C;
      end
      WR_HIGH_S: if (done) begin
        state_nx = IDLE;
        last_nx  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      last_rd <= 1'b0;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
      data_oe <= 1'b0;
      dout    <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      last_rd <= last_nx;
      rd_n    <= (state_nx != RD_LOW_S);
      wr_n    <= (state_nx != WR_LOW_S);
      // Bus stays driven for one hold cycle after wr_n rises.
      data_oe <= (state_nx == WR_SETUP_S) ||
                 (state_nx == WR_LOW_S) ||
                 (state_nx == WR_HIGH_S && state == WR_LOW_S);
      if (tx_pop) dout <= tx_head;
    end
  end

  assign usb_data = data_oe ? dout : 8'hzz;
  assign busy     = (state != IDLE);
  assign rx_valid = !rx_empty;
  assign tx_ready = !tx_full;

  usb_ft_sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .flush   (flush),
    .push    (rx_push),
    .wdata   (usb_data),
    .pop     (rx_valid && rx_ready),
    .rdata   (rx_data),
    .empty   (rx_empty),
    .full    (rx_full),
    .level   (rx_level)
  );

  usb_ft_sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .flush   (flush),
    .push    (tx_valid && tx_ready),
    .wdata   (tx_data),
    .pop     (tx_pop),
    .rdata   (tx_head),
    .empty   (tx_empty),
    .full    (tx_full),
    .level   (tx_level)
  );

endmodule
